hex_keypad_scan: RTL and testbench

Scans a 4x4 matrix hex keypad and assembles accepted key presses into a 16-bit value. It drives one active-low column at a time and samples the active-low rows. Every full four-column sweep (a frame) is debounced, and each accepted key is shifted into a 4-digit register. This is the input-side counterpart of the 4-digit seven-segment display path: `value_out` is shaped to feed the display's 16-bit data input directly.

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/hex_keypad_scan_if.sv | 22 ++
 rtl/sync2.sv | 27 ++
 rtl/hex_keypad_scan.sv | 174 +++++++++++++++++
 tb/tb_hex_keypad_scan.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
//   - kp_state_e  : press/release debounce FSM states
//   - frame_cls_e : classification of one full four-column sweep
//   - row_scan()  : decodes one column's active-high row hits into
//                   {multi, any, row_index}
package keypad_pkg;

  localparam int KP_COLS = 4;
  localparam int KP_ROWS = 4;
  localparam logic [KP_COLS-1:0] COLS_RESET = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_cls_e;

  // The lowest hit row wins the index. That only matters when there is a
  // single hit, because a multi-hit column makes the whole frame MULTI.
  function automatic logic [3:0] row_scan(input logic [KP_ROWS-1:0] low);
    int         n;
    logic [1:0] idx;
    n   = 0;
    idx = 2'd0;
    for (int r = KP_ROWS - 1; r >= 0; r--) begin
      if (low[r]) begin
        n++;
        idx = 2'(r);
      end
    end
    return {(n > 1), (n != 0), idx};
  endfunction

endpackage

// File: rtl/hex_keypad_scan_if.sv
// Keypad scanner signal bundle.
//   master : drives scan_divide_in, rows_in and clear_in (the keypad/host side)
//   slave  : the scanner. It drives cols_out, key_out, key_valid_out and value_out.
interface hex_keypad_scan_if;
  logic [19:0] scan_divide_in;
  logic [3:0]  rows_in;
  logic        clear_in;
  logic [3:0]  cols_out;
  logic [3:0]  key_out;
  logic        key_valid_out;
  logic [15:0] value_out;

  modport master (
    output scan_divide_in, rows_in, clear_in,
    input  cols_out, key_out, key_valid_out, value_out
  );

  modport slave (
    input  scan_divide_in, rows_in, clear_in,
    output cols_out, key_out, key_valid_out, value_out
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with a parameterized width and reset value.
//   clk_in, rst_in : clock and synchronous active-high reset
//   d_i            : asynchronous input
//   q_o            : synchronized output, delayed by two clocks
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/hex_keypad_scan.sv
// 4x4 hex keypad scanner with frame-level debounce and a 4-digit entry register.
//   clk_in, rst_in : clock and synchronous active-high reset
//   kp (slave)     : scan_divide_in (clocks per column), rows_in (active-low),
//                    clear_in, cols_out (active-low one-cold), key_out,
//                    key_valid_out (1-cycle pulse), value_out (newest in [3:0])
module hex_keypad_scan
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic         clk_in,
  input  logic         rst_in,
  hex_keypad_scan_if.slave kp
);
  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_FRAMES);

  logic [KP_ROWS-1:0] rows_sync;

  sync2 #(.W(KP_ROWS), .RST_VAL(4'hF)) u_rows_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_i    (kp.rows_in),
    .q_o    (rows_sync)
  );

  // Scanner. The >= compare lets a divider that shrinks mid-count wrap
  // immediately instead of running through 2^20 clocks.
  logic [19:0]        step_q, step_d, div_m1;
  logic               tick;
  logic [1:0]         col_q;
  logic [KP_COLS-1:0] cols_q;

  always_comb begin
    div_m1 = (kp.scan_divide_in == 20'd0) ? 20'd0 : kp.scan_divide_in - 20'd1;
    tick   = (step_q >= div_m1);
    step_d = tick ? 20'd0 : step_q + 20'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      step_q <= 20'd0;
      col_q  <= 2'd0;
      cols_q <= COLS_RESET;
    end else begin
      step_q <= step_d;
      if (tick) begin
        col_q  <= col_q + 2'd1;
        cols_q <= {cols_q[KP_COLS-2:0], cols_q[KP_COLS-1]};
      end
    end
  end

  assign kp.cols_out = cols_q;

  // Frame classifier. The accumulators hold the result of the columns
  // already sampled in this frame. Column 0 ignores them, so a new frame
  // needs no separate clear.
  logic       acc_any_q, acc_multi_q;
  logic [3:0] acc_key_q;
  logic [3:0] col_hit;
  logic       prev_any, prev_multi;
  logic       frame_any, frame_multi, frame_close;
  logic [3:0] frame_key;
  frame_cls_e fcls;

  always_comb begin
    col_hit     = row_scan(~rows_sync);
    prev_any    = (col_q == 2'd0) ? 1'b0 : acc_any_q;
    prev_multi  = (col_q == 2'd0) ? 1'b0 : acc_multi_q;
    frame_any   = prev_any | col_hit[2];
    frame_multi = prev_multi | col_hit[3] | (prev_any & col_hit[2]);
    frame_key   = prev_any ? acc_key_q : {col_hit[1:0], col_q};
    frame_close = tick & (col_q == 2'd3);
    fcls        = frame_multi ? FR_MULTI : (frame_any ? FR_SINGLE : FR_NONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_any_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_key_q   <= 4'd0;
    end else if (tick) begin
      acc_any_q   <= frame_any;
      acc_multi_q <= frame_multi;
      acc_key_q   <= frame_key;
    end
  end

  // Debounce FSM. It only moves at frame close.
  kp_state_e  state_q, state_d;
  logic [3:0] cand_q, cand_d, cnt_q, cnt_d;
  logic       accept;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (frame_close) begin
      case (state_q)
        ST_IDLE:
          if (fcls == FR_SINGLE) begin
            state_d = ST_PRESS_DB;
            cand_d  = frame_key;
            cnt_d   = 4'd1;
          end
        ST_PRESS_DB:
          if (fcls == FR_SINGLE) begin
            if (frame_key == cand_q) begin
              cnt_d = cnt_q + 4'd1;
              if (cnt_q + 4'd1 == DB_LIMIT) begin
                accept  = 1'b1;
                state_d = ST_HELD;
              end
            end else begin
              cand_d = frame_key;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        ST_HELD:
          if (fcls == FR_NONE) begin
            state_d = ST_RELEASE_DB;
            cnt_d   = 4'd1;
          end
        ST_RELEASE_DB:
          if (fcls == FR_NONE) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB_LIMIT) state_d = ST_IDLE;
          end else begin
            state_d = ST_HELD;
          end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output registers. When a clear and an accept land together, the
  // accepted key survives as the only digit.
  logic [3:0]  key_q;
  logic        kv_q;
  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (kp.clear_in)
      value_d = accept ? {12'h000, cand_q} : 16'h0000;
    else if (accept)
      value_d = {value_q[11:0], cand_q};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= 4'd0;
      key_q   <= 4'd0;
      kv_q    <= 1'b0;
      value_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      kv_q    <= accept;
      value_q <= value_d;
      if (accept) key_q <= cand_q;
    end
  end

  assign kp.key_out       = key_q;
  assign kp.key_valid_out = kv_q;
  assign kp.value_out     = value_q;
endmodule

// File: tb/tb_hex_keypad_scan.sv
// Self-checking bench for hex_keypad_scan (N=4, DEBOUNCE_FRAMES=3).
// A behavioural keypad turns the pressed-key mask plus cols_out into rows_in.
// Each expected accept is queued when its press is driven. A negedge monitor
// pops the queue on every key_valid_out pulse and checks key_out and value_out.
module tb_hex_keypad_scan;
  localparam int FR = 16;  // clocks per frame at N=4

  typedef struct packed {
    logic [3:0]  key;
    logic [15:0] value;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] pressed;
  logic [15:0] exp_value;
  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pulses = 0;

  always #5 clk_in = ~clk_in;

  hex_keypad_scan_if kp ();

  hex_keypad_scan #(.DEBOUNCE_FRAMES(3)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .kp     (kp)
  );

  function automatic logic [3:0] rows_model(input logic [15:0] p, input logic [3:0] cols);
    logic [3:0] r;
    logic [3:0] k;
    r = 4'hF;
    for (int i = 0; i < 16; i++) begin
      k = 4'(i);
      if (p[i] && !cols[k[1:0]]) r[k[3:2]] = 1'b0;
    end
    return r;
  endfunction

  assign kp.rows_in = rows_model(pressed, kp.cols_out);

  // Scoreboard monitor
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (!rst_in && kp.key_valid_out === 1'b1) begin
      pulses++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: key_out=%h value_out=%h, required no pulse",
                 kp.key_out, kp.value_out);
      end else begin
        e = sb.pop_front();
        if (kp.key_out !== e.key) begin
          miscompares++;
          $display("FAIL pulse_key: got %h, required %h", kp.key_out, e.key);
        end
        vectors++;
        if (kp.value_out !== e.value) begin
          miscompares++;
          $display("FAIL pulse_value: got %h, required %h", kp.value_out, e.value);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic frames(input int n);
    repeat (n * FR) @(negedge clk_in);
  endtask

  task automatic expect_key(input logic [3:0] k);
    exp_t e;
    exp_value = {exp_value[11:0], k};
    e.key     = k;
    e.value   = exp_value;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_pulse: %0d pulses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_pulses(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s_pulse_count: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_value(input string name, input logic [15:0] want);
    vectors++;
    if (kp.value_out !== want) begin
      miscompares++;
      $display("FAIL %s_value: got %h, required %h", name, kp.value_out, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (kp.cols_out !== 4'b1110 || kp.key_out !== 4'h0 ||
        kp.key_valid_out !== 1'b0 || kp.value_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL %s: cols=%b key=%h kv=%b value=%h, required 1110 0 0 0000",
               name, kp.cols_out, kp.key_out, kp.key_valid_out, kp.value_out);
    end
  endtask

  task automatic press_release(input logic [3:0] k);
    expect_key(k);
    pressed    = '0;
    pressed[k] = 1'b1;
    frames(4);
    pressed = '0;
    frames(6);
  endtask

  task automatic test_reset;
    logic [3:0] ec;
    rst_in               = 1'b1;
    pressed              = '0;
    kp.clear_in          = 1'b0;
    kp.scan_divide_in    = 20'd4;
    exp_value            = 16'h0000;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset_state");
    rst_in = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ec = ~(4'b0001 << ((i / 4) % 4));
      vectors++;
      if (kp.cols_out !== ec || kp.key_valid_out !== 1'b0 || kp.value_out !== 16'h0000) begin
        miscompares++;
        $display("FAIL scan_cycle%0d: cols=%b kv=%b value=%h, required %b 0 0000",
                 i, kp.cols_out, kp.key_valid_out, kp.value_out, ec);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_single_press;
    int p0;
    p0 = pulses;
    expect_key(4'h6);
    pressed    = '0;
    pressed[6] = 1'b1;
    frames(6);
    pressed = '0;
    frames(6);
    drain("single_press");
    check_pulses("single_press", pulses - p0, 1);
  endtask

  task automatic test_digit_entry;
    press_release(4'h1);
    press_release(4'h2);
    press_release(4'h3);
    press_release(4'h4);
    drain("digits");
    check_value("digits_1234", 16'h1234);
    press_release(4'hA);
    drain("digit_a");
    check_value("digits_234a", 16'h234A);
  endtask

  task automatic test_bounce;
    int p0;
    p0         = pulses;
    pressed    = '0;
    pressed[5] = 1'b1;
    repeat (2 * FR) @(negedge clk_in);
    pressed = '0;
    repeat (FR) @(negedge clk_in);
    pressed[5] = 1'b1;
    repeat (2 * FR) @(negedge clk_in);
    check_pulses("bounce_reject", pulses - p0, 0);
    expect_key(4'h5);
    repeat (FR) @(negedge clk_in);
    pressed = '0;
    frames(6);
    drain("bounce_accept");
    check_pulses("bounce_accept", pulses - p0, 1);
  endtask

  task automatic test_multi_key;
    int p0;
    p0          = pulses;
    pressed     = '0;
    pressed[0]  = 1'b1;
    pressed[15] = 1'b1;
    frames(5);
    check_pulses("multi_reject", pulses - p0, 0);
    expect_key(4'h0);
    pressed[15] = 1'b0;
    frames(5);
    pressed = '0;
    frames(6);
    drain("multi_accept");
    check_pulses("multi_accept", pulses - p0, 1);
  endtask

  task automatic test_clear_accept;
    logic [3:0] prev;
    bit         found;
    press_release(4'hA);
    press_release(4'hB);
    press_release(4'hC);
    press_release(4'hD);
    drain("abcd");
    check_value("abcd", 16'hABCD);
    // Align to the first cycle of a frame so the accept cycle is known.
    found = 1'b0;
    prev  = kp.cols_out;
    for (int i = 0; i < 4 * FR && !found; i++) begin
      @(negedge clk_in);
      if (prev == 4'b0111 && kp.cols_out == 4'b1110) found = 1'b1;
      prev = kp.cols_out;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL frame_align: frame start not seen, required within %0d clocks", 4 * FR);
    end
    exp_value = 16'h0000;
    expect_key(4'h9);
    pressed    = '0;
    pressed[9] = 1'b1;
    // The third frame closes on cycle 48 of the alignment, so clear goes
    // high for exactly that cycle.
    repeat (3 * FR - 1) @(negedge clk_in);
    kp.clear_in = 1'b1;
    vectors++;
    if (kp.key_valid_out !== 1'b0 || kp.value_out !== 16'hABCD) begin
      miscompares++;
      $display("FAIL pre_accept: kv=%b value=%h, required 0 abcd", kp.key_valid_out, kp.value_out);
    end
    @(negedge clk_in);
    kp.clear_in = 1'b0;
    frames(3);
    pressed = '0;
    frames(6);
    drain("clear_accept");
    check_value("clear_accept_hold", 16'h0009);
    kp.clear_in = 1'b1;
    @(negedge clk_in);
    kp.clear_in = 1'b0;
    exp_value   = 16'h0000;
    check_value("plain_clear", 16'h0000);
  endtask

  task automatic test_reset_mid_debounce;
    int p0;
    press_release(4'h3);
    drain("pre_reset");
    pressed    = '0;
    pressed[7] = 1'b1;
    frames(2);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check_reset_outputs("mid_debounce_reset");
    pressed   = '0;
    rst_in    = 1'b0;
    exp_value = 16'h0000;
    p0        = pulses;
    frames(6);
    check_pulses("after_reset", pulses - p0, 0);
    check_value("after_reset", 16'h0000);
    vectors++;
    if (kp.key_out !== 4'h0) begin
      miscompares++;
      $display("FAIL after_reset_key: got %h, required 0", kp.key_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_digit_entry();
    test_bounce();
    test_multi_key();
    test_clear_accept();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
